// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event unit.
package key_event_pkg;

    // Key tracking states used by the hold-to-repeat logic.
    typedef enum logic [1:0] {
        KE_IDLE   = 2'd0,
        KE_HOLD   = 2'd1,
        KE_REPEAT = 2'd2
    } ke_state_t;

    // Hold counter width: wide enough for the larger of the two repeat intervals.
    function automatic int ke_cnt_width(input int delay, input int period);
        int m;
        m = (delay > period) ? delay : period;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_event_if.sv
// One-entry valid/ready event channel from the key event unit to the terminal FSM.
interface key_event_if
    import key_event_pkg::*;
#(
    parameter int CODE_W = 2
);
    logic              KeyValid;
    logic              KeyReady;
    logic [CODE_W-1:0] KeyCode;
    logic              KeyRepeat;
    logic              KeyDrop;

    modport master (output KeyValid, KeyCode, KeyRepeat, KeyDrop, input KeyReady);
    modport slave  (input KeyValid, KeyCode, KeyRepeat, KeyDrop, output KeyReady);
endinterface

// File: rtl/key_priority_encoder.sv
// Picks the lowest-index rising key and flags when more than one key rose.
module key_priority_encoder
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int CODE_W   = $clog2(NUM_KEYS)
) (
    input  logic [NUM_KEYS-1:0] rise,
    output logic [CODE_W-1:0]   win_idx,
    output logic                any_rise,
    output logic                multi_rise
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (rise[i]) win_idx = CODE_W'(i);
        end
        any_rise   = |rise;
        multi_rise = |(rise & (rise - NUM_KEYS'(1)));
    end

endmodule

// File: rtl/key_event_unit.sv
// Turns debounced key levels into single key-press events on a one-entry slot.
// Hold-to-repeat is compiled in only when KEY_AUTO_REPEAT_EN is defined.
//
//   state     | meaning
//   KE_IDLE   | no key tracked
//   KE_HOLD   | key tracked, counting toward the first repeat
//   KE_REPEAT | key tracked, counting the repeat period
module key_event_unit
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NUM_KEYS-1:0] KeyIn,
    key_event_if.master         evt
);

    localparam int CODE_W = $clog2(NUM_KEYS);

    if (NUM_KEYS < 2 || NUM_KEYS > 16 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("key_event_unit: unsupported parameter set");
    end

    logic [NUM_KEYS-1:0] key_prev;
    logic [NUM_KEYS-1:0] rise_q;
    logic [CODE_W-1:0]   win_idx;
    logic                any_rise;
    logic                multi_rise;
    logic                ev_valid;
    logic [CODE_W-1:0]   ev_code;
    logic                ev_rep;
    logic                slot_valid;
    logic [CODE_W-1:0]   slot_code;
    logic                slot_rep;
    logic                drop_q;
    logic                load_ok;

    // Edge detect; key_prev follows KeyIn during reset so held keys never fire.
    always_ff @(posedge CLK) begin
        key_prev <= KeyIn;
        if (!RST_N) rise_q <= '0;
        else        rise_q <= KeyIn & ~key_prev;
    end

    key_priority_encoder #(
        .NUM_KEYS (NUM_KEYS),
        .CODE_W   (CODE_W)
    ) u_prio (
        .rise       (rise_q),
        .win_idx    (win_idx),
        .any_rise   (any_rise),
        .multi_rise (multi_rise)
    );

`ifdef KEY_AUTO_REPEAT_EN
    localparam int CNT_W = ke_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    ke_state_t         state, state_nxt;
    logic [CNT_W-1:0]  hold_cnt, hold_cnt_nxt;
    logic [CODE_W-1:0] held_key, held_key_nxt;

    // Tracker registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= KE_IDLE;
            hold_cnt <= '0;
            held_key <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            held_key <= held_key_nxt;
        end
    end

    // New presses preempt everything; a release beats a same-cycle repeat.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        held_key_nxt = held_key;
        ev_valid     = 1'b0;
        ev_code      = win_idx;
        ev_rep       = 1'b0;
        if (any_rise) begin
            ev_valid     = 1'b1;
            state_nxt    = KE_HOLD;
            held_key_nxt = win_idx;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                KE_HOLD, KE_REPEAT: begin
                    if (!key_prev[held_key]) begin
                        state_nxt    = KE_IDLE;
                        hold_cnt_nxt = '0;
                    end else if (hold_cnt == ((state == KE_HOLD) ? DLY_LAST : PER_LAST)) begin
                        ev_valid     = 1'b1;
                        ev_code      = held_key;
                        ev_rep       = 1'b1;
                        state_nxt    = KE_REPEAT;
                        hold_cnt_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt    = KE_IDLE;
                    hold_cnt_nxt = '0;
                end
            endcase
        end
    end
`else
    assign ev_valid = any_rise;
    assign ev_code  = win_idx;
    assign ev_rep   = 1'b0;
`endif

    assign load_ok = !slot_valid || evt.KeyReady;

    // Single-entry output slot; a blocked event or any losing rise pulses the drop flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            slot_valid <= 1'b0;
            slot_code  <= '0;
            slot_rep   <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= (any_rise && multi_rise) || (ev_valid && !load_ok);
            if (ev_valid && load_ok) begin
                slot_valid <= 1'b1;
                slot_code  <= ev_code;
                slot_rep   <= ev_rep;
            end else if (slot_valid && evt.KeyReady) begin
                slot_valid <= 1'b0;
            end
        end
    end

    assign evt.KeyValid  = slot_valid;
    assign evt.KeyCode   = slot_code;
    assign evt.KeyRepeat = slot_rep;
    assign evt.KeyDrop   = drop_q;

endmodule

// File: tb/tb_key_event_unit.sv
// Bench for key_event_unit: directed test-plan steps followed by random key/ready traffic,
// all checked against a reference model that tracks repeat times as absolute cycle numbers.
module tb_key_event_unit;

    localparam int NK  = 4;
    localparam int DLY = 10;
    localparam int PER = 4;
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit AUTO_REP = 1'b1;
`else
    localparam bit AUTO_REP = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [NK-1:0] KeyIn;

    key_event_if #(.CODE_W(2)) kif ();

    key_event_unit #(
        .NUM_KEYS      (NK),
        .REPEAT_DELAY  (DLY),
        .REPEAT_PERIOD (PER)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .KeyIn (KeyIn),
        .evt   (kif)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    logic [NK-1:0] m_prev = '0;
    logic [NK-1:0] m_rise = '0;
    bit            m_valid, m_rep, m_drop, m_track;
    logic [1:0]    m_code;
    int            m_held, m_due;

    // observation counters for directed steps
    int ev_seen, rep_seen, drop_seen, xfer_cnt;
    logic [1:0] last_xfer_code;
    int valid_cycles[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        ev_seen = 0; rep_seen = 0; drop_seen = 0; xfer_cnt = 0;
        valid_cycles.delete();
    endtask

    // Advance one clock: predict the edge from the model, then compare the DUT after it.
    task automatic tick();
        bit         ev, loser, ld_ok, ev_rep;
        logic [1:0] ev_code;
        int         w;
        if (kif.KeyValid === 1'b1 && kif.KeyReady === 1'b1) begin
            xfer_cnt++;
            last_xfer_code = kif.KeyCode;
        end
        if (!RST_N) begin
            m_rise = '0; m_valid = 0; m_code = '0; m_rep = 0; m_drop = 0;
            m_track = 0; m_held = 0; m_due = 0;
        end else begin
            ev = 0; loser = 0; ev_rep = 0; ev_code = '0;
            if (m_rise != '0) begin
                w = NK;
                for (int i = NK - 1; i >= 0; i--) if (m_rise[i]) w = i;
                ev      = 1;
                ev_code = 2'(w);
                loser   = ($countones(m_rise) > 1);
                m_track = 1;
                m_held  = w;
                m_due   = cyc + DLY;
            end
`ifdef KEY_AUTO_REPEAT_EN
            else if (m_track) begin
                if (!m_prev[m_held]) m_track = 0;
                else if (cyc == m_due) begin
                    ev = 1; ev_code = 2'(m_held); ev_rep = 1;
                    m_due = cyc + PER;
                end
            end
`endif
            ld_ok  = !m_valid || kif.KeyReady;
            m_drop = loser || (ev && !ld_ok);
            if (ev && ld_ok) begin
                m_valid = 1; m_code = ev_code; m_rep = ev_rep;
            end else if (m_valid && kif.KeyReady) begin
                m_valid = 0;
            end
            m_rise = KeyIn & ~m_prev;
        end
        m_prev = KeyIn;
        @(posedge CLK);
        #1;
        chk("valid",  32'(kif.KeyValid),  32'(m_valid));
        chk("code",   32'(kif.KeyCode),   32'(m_code));
        chk("repeat", 32'(kif.KeyRepeat), 32'(m_rep));
        chk("drop",   32'(kif.KeyDrop),   32'(m_drop));
        if (kif.KeyValid === 1'b1) begin
            ev_seen++;
            valid_cycles.push_back(cyc);
            if (kif.KeyRepeat === 1'b1) rep_seen++;
        end
        if (kif.KeyDrop === 1'b1) drop_seen++;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int press_cyc;
        int ofs[6];
        ofs = '{0, 10, 14, 18, 22, 26};

        // reset with a key already held across release
        RST_N = 1'b0; KeyIn = 4'b0010; kif.KeyReady = 1'b1;
        ticks(3);
        chk("rst_valid", 32'(kif.KeyValid), 32'd0);
        chk("rst_code",  32'(kif.KeyCode),  32'd0);
        RST_N = 1'b1;
        clear_obs();
        ticks(20);
        chk("held_rst_events", 32'(ev_seen),   32'd0);
        chk("held_rst_drops",  32'(drop_seen), 32'd0);

        // single press: one-cycle latency, one-cycle valid with ready high
        KeyIn = 4'b0000; ticks(3);
        clear_obs();
        KeyIn = 4'b0100; press_cyc = cyc;
        tick();
        chk("lat_early", 32'(kif.KeyValid), 32'd0);
        tick();
        chk("lat_valid", 32'(kif.KeyValid), 32'd1);
        chk("lat_code",  32'(kif.KeyCode),  32'd2);
        chk("lat_rep",   32'(kif.KeyRepeat), 32'd0);
        chk("lat_cycle", 32'(valid_cycles.size() > 0 ? valid_cycles[0] : -1), 32'(press_cyc + 1));
        tick();
        chk("one_cycle", 32'(kif.KeyValid), 32'd0);
        KeyIn = 4'b0000; ticks(3);

        // two simultaneous rises: lowest wins, one drop pulse
        clear_obs();
        KeyIn = 4'b1010; ticks(2);
        chk("multi_code", 32'(kif.KeyCode), 32'd1);
        chk("multi_drop", 32'(kif.KeyDrop), 32'd1);
        ticks(2);
        chk("multi_drop_cnt", 32'(drop_seen), 32'd1);
        KeyIn = 4'b0000; ticks(3);

        // blocked slot: second press dropped, first one transfers alone
        kif.KeyReady = 1'b0;
        clear_obs();
        KeyIn = 4'b0001; ticks(2);
        KeyIn = 4'b1001; ticks(2);
        chk("blk_drop",  32'(kif.KeyDrop), 32'd1);
        chk("blk_code",  32'(kif.KeyCode), 32'd0);
        KeyIn = 4'b0000; tick();
        chk("blk_hold",  32'(kif.KeyValid), 32'd1);
        kif.KeyReady = 1'b1;
        ticks(3);
        chk("blk_xfer_cnt",  32'(xfer_cnt), 32'd1);
        chk("blk_xfer_code", 32'(last_xfer_code), 32'd0);
        chk("blk_drop_cnt",  32'(drop_seen), 32'd1);
        ticks(2);

        // hold key 1 for 30 cycles
        clear_obs();
        KeyIn = 4'b0010; ticks(30);
        KeyIn = 4'b0000; ticks(15);
        chk("hold_events",  32'(ev_seen),  AUTO_REP ? 32'd6 : 32'd1);
        chk("hold_repeats", 32'(rep_seen), AUTO_REP ? 32'd5 : 32'd0);
        if (AUTO_REP && valid_cycles.size() == 6) begin
            for (int i = 1; i < 6; i++)
                chk("hold_offset", 32'(valid_cycles[i] - valid_cycles[0]), 32'(ofs[i]));
        end

        // random key and ready traffic with a reset in the middle
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < NK; b++)
                if ($urandom_range(0, 9) == 0) KeyIn[b] = ~KeyIn[b];
            kif.KeyReady = ($urandom_range(0, 3) != 0);
            RST_N = !(n >= 400 && n < 402);
            tick();
        end
        RST_N = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
